// File: rtl/datain_buf_rx.sv
// Receive-side capture buffer: stores one packet of DEPTH flits from the upstream
// dataout buffer and offers registered random-access readback of the capture.
module datain_buf_rx #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 30
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] datain,
  input  logic             in_valid,
  input  logic             clear,
  input  logic [4:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [4:0]       flit_cnt,
  output logic             recv_done,
  output logic             overflow,
  output logic [1:0]       fsm_state
);

  // Flow contract: in_valid qualifies datain for exactly one cycle and there is
  // no ready/backpressure; a flit presented while clear=1 or in DONE is dropped.

  localparam int AW = 5;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL_CNT  = AW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    wr_addr_q;
  logic [AW-1:0]    flit_cnt_q;
  logic             recv_done_q;
  logic             overflow_q;
  logic [WIDTH-1:0] rd_data_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             rd_in_range;

  // Write strobe: clear always wins, and DONE never writes, so the
  // write address can never leave 0..DEPTH-1.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    if (!clear && in_valid) begin
      case (state_q)
        ST_IDLE: begin
          mem_we    = 1'b1;
          mem_waddr = '0;
        end
        ST_RECV: begin
          mem_we    = 1'b1;
          mem_waddr = wr_addr_q;
        end
        default: begin
          mem_we    = 1'b0;
          mem_waddr = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      flit_cnt_q  <= '0;
      recv_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      flit_cnt_q  <= '0;
      recv_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            wr_addr_q  <= AW'(1);
            flit_cnt_q <= AW'(1);
            state_q    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (in_valid) begin
            if (wr_addr_q == LAST_ADDR) begin
              // wr_addr parks on the last slot rather than wrapping.
              flit_cnt_q  <= FULL_CNT;
              recv_done_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              wr_addr_q  <= wr_addr_q + AW'(1);
              flit_cnt_q <= flit_cnt_q + AW'(1);
            end
          end
        end
        ST_DONE: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture storage is deliberately not reset; contents survive RST and clear.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= datain;
    end
  end

  assign rd_in_range = (rd_addr <= LAST_ADDR);

  // Nonblocking read of mem_q gives read-before-write on a same-address collision.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data   = rd_data_q;
  assign flit_cnt  = flit_cnt_q;
  assign recv_done = recv_done_q;
  assign overflow  = overflow_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_datain_buf_rx.sv
// Directed bench for datain_buf_rx: a vector table for the straight capture,
// readback and overflow, then hand sequences for reset abort, clear, and gaps.
module tb_datain_buf_rx;

  localparam int W = 20;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic         clk = 1'b0;
  logic         RST;
  logic [W-1:0] datain;
  logic         in_valid;
  logic         clear;
  logic [4:0]   rd_addr;
  logic [W-1:0] rd_data;
  logic [4:0]   flit_cnt;
  logic         recv_done;
  logic         overflow;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [4:0]   ra;
    logic         chk_rd;
    logic [W-1:0] e_rd;
    logic [4:0]   e_cnt;
    logic         e_done;
    logic         e_ovf;
  } vec_t;

  vec_t tbl[64];

  // clock / reset
  always #5 clk = ~clk;

  datain_buf_rx #(.WIDTH(W), .DEPTH(30)) dut (
    .clk       (clk),
    .RST       (RST),
    .datain    (datain),
    .in_valid  (in_valid),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .flit_cnt  (flit_cnt),
    .recv_done (recv_done),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver: present inputs, take one rising edge, sample 1 time unit later
  task automatic apply(input logic v, input logic [W-1:0] d, input logic [4:0] ra,
                       input logic clr);
    in_valid = v;
    datain   = d;
    rd_addr  = ra;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string name, input logic [4:0] cnt, input logic done,
                           input logic ovf);
    chk({name, "_cnt"},  {27'd0, flit_cnt}, {27'd0, cnt});
    chk({name, "_done"}, {31'd0, recv_done}, {31'd0, done});
    chk({name, "_ovf"},  {31'd0, overflow},  {31'd0, ovf});
  endtask

  initial begin
    RST = 1'b0; datain = '0; in_valid = 1'b0; clear = 1'b0; rd_addr = '0;

    for (int i = 0; i < 30; i++)
      tbl[i] = '{1'b1, W'(i), 5'd0, 1'b0, '0, 5'(i + 1), (i == 29), 1'b0};
    for (int k = 0; k < 30; k++)
      tbl[30 + k] = '{1'b0, '0, 5'(k), 1'b1, W'(k), 5'd30, 1'b1, 1'b0};
    tbl[60] = '{1'b1, 20'hFFFFF, 5'd0, 1'b0, '0, 5'd30, 1'b1, 1'b1};
    tbl[61] = '{1'b1, 20'hFFFFF, 5'd0, 1'b0, '0, 5'd30, 1'b1, 1'b1};
    tbl[62] = '{1'b0, '0, 5'd0,  1'b1, 20'h00000, 5'd30, 1'b1, 1'b1};
    tbl[63] = '{1'b0, '0, 5'd29, 1'b1, 20'h0001D, 5'd30, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset", 5'd0, 1'b0, 1'b0);
    chk("reset_rd", {12'd0, rd_data}, 32'd0);
    chk("reset_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    RST = 1'b1;

    // straight capture, full readback, overflow with memory untouched
    for (int r = 0; r < 64; r++) begin
      apply(tbl[r].v, tbl[r].d, tbl[r].ra, 1'b0);
      chk_flags($sformatf("tbl%0d", r), tbl[r].e_cnt, tbl[r].e_done, tbl[r].e_ovf);
      if (tbl[r].chk_rd)
        chk($sformatf("tbl%0d_rd", r), {12'd0, rd_data}, {12'd0, tbl[r].e_rd});
    end
    chk("tbl_state", {30'd0, fsm_state}, {30'd0, S_DONE});

    // asynchronous reset from DONE, then abort a partial capture
    RST = 1'b0;
    #1;
    chk_flags("async_rst", 5'd0, 1'b0, 1'b0);
    chk("async_rst_rd", {12'd0, rd_data}, 32'd0);
    chk("async_rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    RST = 1'b1;
    for (int i = 0; i < 12; i++) apply(1'b1, 20'hB0000 + W'(i), 5'd0, 1'b0);
    chk_flags("pre_abort", 5'd12, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    chk_flags("abort", 5'd0, 1'b0, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 30; i++) begin
      apply(1'b1, 20'hA0000 + W'(i), 5'd0, 1'b0);
      chk_flags($sformatf("rcap%0d", i), 5'(i + 1), (i == 29), 1'b0);
    end
    apply(1'b0, '0, 5'd0, 1'b0);
    chk("rcap_mem0", {12'd0, rd_data}, 32'hA0000);
    apply(1'b0, '0, 5'd11, 1'b0);
    chk("rcap_mem11", {12'd0, rd_data}, 32'hA000B);

    // clear together with in_valid in DONE drops the flit
    apply(1'b1, 20'hFFFFF, 5'd0, 1'b0);
    chk_flags("ovf_set", 5'd30, 1'b1, 1'b1);
    apply(1'b1, 20'h12345, 5'd0, 1'b1);
    chk_flags("clr_done", 5'd0, 1'b0, 1'b0);
    chk("clr_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    apply(1'b0, '0, 5'd0, 1'b0);
    chk("clr_mem0_kept", {12'd0, rd_data}, 32'hA0000);
    apply(1'b1, 20'h55555, 5'd0, 1'b0);
    chk_flags("post_clr", 5'd1, 1'b0, 1'b0);
    chk("post_clr_state", {30'd0, fsm_state}, {30'd0, S_RECV});
    chk("post_clr_rbw0", {12'd0, rd_data}, 32'hA0000);
    apply(1'b0, '0, 5'd0, 1'b0);
    chk("post_clr_mem0", {12'd0, rd_data}, 32'h55555);

    // out-of-range reads and read-before-write at mem[5]
    apply(1'b0, '0, 5'd30, 1'b0);
    chk("rd30", {12'd0, rd_data}, 32'd0);
    apply(1'b0, '0, 5'd1, 1'b0);
    chk("rd1", {12'd0, rd_data}, 32'hA0001);
    apply(1'b0, '0, 5'd31, 1'b0);
    chk("rd31", {12'd0, rd_data}, 32'd0);
    for (int i = 1; i < 5; i++) apply(1'b1, 20'h10000 + W'(i), 5'd0, 1'b0);
    apply(1'b1, 20'h77777, 5'd5, 1'b0);
    chk("rbw5_old", {12'd0, rd_data}, 32'hA0005);
    chk_flags("rbw5", 5'd6, 1'b0, 1'b0);
    apply(1'b0, '0, 5'd5, 1'b0);
    chk("rbw5_new", {12'd0, rd_data}, 32'h77777);

    // gapped capture must rebuild mem[k] = k over the 0xA0000 pattern
    apply(1'b0, '0, 5'd0, 1'b1);
    chk_flags("clr_gap", 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        apply(1'b0, 20'hFFFFF, 5'd0, 1'b0);
        chk_flags($sformatf("gap%0d", i), 5'(i), 1'b0, 1'b0);
      end
      apply(1'b1, W'(i), 5'd0, 1'b0);
      chk_flags($sformatf("gcap%0d", i), 5'(i + 1), (i == 29), 1'b0);
    end
    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] e;
      exp_q.push_back(W'(k));
      apply(1'b0, '0, 5'(k), 1'b0);
      e = exp_q.pop_front();
      chk($sformatf("grd%0d", k), {12'd0, rd_data}, {12'd0, e});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
